// File: rtl/arbitro_mux8_32_pkg.sv
// rtl/arbitro_mux8_32_pkg.sv - shared frame constants for the round-robin byte scheduler
package arbitro_mux8_32_pkg;

  localparam int FRAME_SLOTS = 4;
  localparam int PHASE_W     = 2;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t     FIRST_PHASE = phase_t'(0);
  localparam phase_t     LAST_PHASE  = phase_t'(FRAME_SLOTS - 1);
  localparam logic [7:0] IDLE_BYTE   = 8'h00;

endpackage

// File: rtl/arbitro_mux8_32_if.sv
// rtl/arbitro_mux8_32_if.sv - requester/packer bundle around the frame scheduler
interface arbitro_mux8_32_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        valid_in;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         data_out;
  logic                      valid_out;
  logic                      sof;
  logic                      frame_valid;
  logic [ID_W-1:0]           grant_id;

  modport master (
    output req, valid_in, data_in,
    input  ack, data_out, valid_out, sof, frame_valid, grant_id
  );

  modport slave (
    input  req, valid_in, data_in,
    output ack, data_out, valid_out, sof, frame_valid, grant_id
  );

endinterface

// File: rtl/arbitro_mux8_32_rr_picker.sv
// rtl/arbitro_mux8_32_rr_picker.sv - combinational round-robin search starting after the last winner
module arbitro_mux8_32_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  int idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/arbitro_mux8_32.sv
// rtl/arbitro_mux8_32.sv - grants one lane per 4-slot frame and forwards its bytes slot-aligned
module arbitro_mux8_32
  import arbitro_mux8_32_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic              clk_4f,
  input  logic              reset,
  arbitro_mux8_32_if.slave  bus
);

  if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_err
    $fatal(1, "arbitro_mux8_32: ID_W must equal clog2(NUM_REQ), NUM_REQ in 2..8");
  end

  phase_t            phase_q, phase_d;
  logic              grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              sof_q, sof_d;
  logic              frame_valid_q, frame_valid_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;

  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_REQ-1:0] ack_c;

  arbitro_mux8_32_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  // Lane select for the locked grant; ack only ever targets the owner of the current frame.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    ack_c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid = grant_valid_q & bus.valid_in[i];
        sel_data  = bus.data_in[i*DATA_W +: DATA_W];
        ack_c[i]  = grant_valid_q & bus.valid_in[i];
      end
    end
  end

  always_comb begin
    phase_d       = phase_q + phase_t'(1);
    grant_valid_d = grant_valid_q;
    grant_d       = grant_q;
    last_d        = last_q;
    // Arbitrate only on the last slot so the grant is stable for the whole next frame.
    if (phase_q == LAST_PHASE) begin
      grant_valid_d = any_req;
      if (any_req) begin
        grant_d = winner;
        last_d  = winner;
      end
    end
    valid_out_d   = sel_valid;
    data_out_d    = sel_valid ? sel_data : DATA_W'(IDLE_BYTE);
    sof_d         = (phase_q == FIRST_PHASE);
    frame_valid_d = grant_valid_q;
    grant_id_d    = grant_q;
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      phase_q       <= FIRST_PHASE;
      grant_valid_q <= 1'b0;
      grant_q       <= '0;
      last_q        <= ID_W'(NUM_REQ - 1);
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      sof_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      grant_id_q    <= '0;
    end else begin
      phase_q       <= phase_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      sof_q         <= sof_d;
      frame_valid_q <= frame_valid_d;
      grant_id_q    <= grant_id_d;
    end
  end

  assign bus.ack         = ack_c;
  assign bus.data_out    = data_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.sof         = sof_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_arbitro_mux8_32.sv
// tb/tb_arbitro_mux8_32.sv - directed and random checks of the frame scheduler against a frame-level model
module tb_arbitro_mux8_32;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  arbitro_mux8_32_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus();

  arbitro_mux8_32 #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk_4f (clk),
    .reset  (rst),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  // Frame-level model: slot position, owner of the current frame, rotation pointer.
  int   m_slot;
  int   m_owner;
  int   m_last;
  bit   m_owned;

  logic [NUM_REQ-1:0] in_req;
  logic [NUM_REQ-1:0] in_valid;
  logic [7:0]         in_data [NUM_REQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot  = 0;
    m_owner = 0;
    m_last  = NUM_REQ - 1;
    m_owned = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ack"},         32'(bus.ack),         32'h0);
    chk({tag, ".data_out"},    32'(bus.data_out),    32'h0);
    chk({tag, ".valid_out"},   32'(bus.valid_out),   32'h0);
    chk({tag, ".sof"},         32'(bus.sof),         32'h0);
    chk({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'h0);
    chk({tag, ".grant_id"},    32'(bus.grant_id),    32'h0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input string tag);
    logic [NUM_REQ-1:0] e_ack;
    bit                 e_v, e_sof, e_fv, found;
    logic [7:0]         e_d;
    int                 e_gid, c;
    bus.req      = in_req;
    bus.valid_in = in_valid;
    for (int i = 0; i < NUM_REQ; i++) bus.data_in[i*DATA_W +: DATA_W] = in_data[i];
    #1;
    e_ack = '0;
    if (m_owned && in_valid[m_owner]) e_ack[m_owner] = 1'b1;
    chk({tag, ".ack"}, 32'(bus.ack), 32'(e_ack));
    e_v   = m_owned && in_valid[m_owner];
    e_d   = e_v ? in_data[m_owner] : 8'h00;
    e_sof = (m_slot == 0);
    e_fv  = m_owned;
    e_gid = m_owner;
    if (m_slot == 3) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_last + k) % NUM_REQ;
        if (!found && in_req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_last  = c;
        end
      end
      m_owned = found;
    end
    m_slot = (m_slot + 1) % 4;
    @(posedge clk);
    #1;
    chk({tag, ".valid_out"},   32'(bus.valid_out),   32'(e_v));
    chk({tag, ".data_out"},    32'(bus.data_out),    32'(e_d));
    chk({tag, ".sof"},         32'(bus.sof),         32'(e_sof));
    chk({tag, ".frame_valid"}, 32'(bus.frame_valid), 32'(e_fv));
    chk({tag, ".grant_id"},    32'(bus.grant_id),    32'(e_gid));
    @(negedge clk);
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < NUM_REQ; i++) in_data[i] = 8'($urandom);
  endtask

  logic [7:0] single_bytes [4];
  logic [7:0] bubble_bytes [4];
  int         n;

  initial begin
    single_bytes = '{8'h2A, 8'h59, 8'h88, 8'hB7};
    bubble_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    in_req   = '0;
    in_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) in_data[i] = 8'h00;
    bus.req      = '0;
    bus.valid_in = '0;
    bus.data_in  = '0;
    model_reset();

    // Reset held for three edges.
    @(negedge clk);
    check_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b0;

    // Idle frames: sof keeps pulsing, nothing granted.
    for (int s = 0; s < 8; s++) step("idle");

    // Single lane back-to-back, fixed byte sequence per slot.
    in_req   = 4'b0001;
    in_valid = 4'b0001;
    for (int s = 0; s < 16; s++) begin
      in_data[0] = single_bytes[m_slot];
      step("single");
    end

    // Contention between lanes 0 and 2, all lanes presenting data.
    in_req = 4'b0101;
    for (int s = 0; s < 20; s++) begin
      in_valid = 4'b1111;
      randomize_lanes();
      step("contend");
    end

    // Bubble on lane 1 in slot 2.
    in_req = 4'b0010;
    for (int s = 0; s < 16; s++) begin
      in_data[1]  = bubble_bytes[m_slot];
      in_valid[1] = (m_slot != 2);
      step("bubble");
    end

    // Lane 3 drops req at phase 1 of its own frame.
    in_req   = 4'b1000;
    in_valid = 4'b1111;
    n = 0;
    while (!(m_owned && m_owner == 3 && m_slot == 1) && n < 64) begin
      randomize_lanes();
      step("drop_wait");
      n++;
    end
    chk("drop_reached", 32'(n < 64), 32'h1);
    in_req = '0;
    for (int s = 0; s < 10; s++) begin
      randomize_lanes();
      step("drop");
    end

    // Random traffic.
    for (int s = 0; s < 300; s++) begin
      in_req   = NUM_REQ'($urandom);
      in_valid = NUM_REQ'($urandom);
      randomize_lanes();
      step("random");
    end

    // Reset asserted mid-frame while lane 2 owns the frame.
    in_req   = 4'b1111;
    in_valid = 4'b1111;
    n = 0;
    while (!(m_owned && m_owner == 2 && m_slot == 2) && n < 64) begin
      randomize_lanes();
      step("mid_wait");
      n++;
    end
    chk("mid_reached", 32'(n < 64), 32'h1);
    chk("mid_pre_fv", 32'(bus.frame_valid), 32'h1);
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 16; s++) begin
      randomize_lanes();
      step("post_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
